// File: rtl/sudoku_board_loader.sv
// sudoku_board_loader: feeds spaced single-cycle write strobes to the solver from a bulk board load or single digits
module sudoku_board_loader #(
  parameter int CELLS = 81,
  parameter int POS_W = 7,
  parameter int GAP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [CELLS*4-1:0] init_board,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic [POS_W-1:0]   digit_pos,
  input  logic [3:0]         digit_val,
  output logic               read,
  output logic [POS_W-1:0]   block_pos,
  output logic [3:0]         data,
  output logic               busy,
  output logic               load_done,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, BULK, SINGLE, GAP_WAIT} state_t;
  state_t state;
  logic [POS_W-1:0] idx;
  logic [3:0] gap_cnt;
  logic bulk;
  logic [3:0] shadow [CELLS];
  logic [POS_W-1:0] nxt;
  logic last, step;
  assign nxt = idx + 1'b1;
  assign last = idx == POS_W'(CELLS - 1);
  assign step = (state == GAP_WAIT) ? gap_cnt == 4'(GAP - 1) : GAP == 0;
  assign digit_ready = state == IDLE && !load_start;
  // Board snapshot so later init_board changes cannot disturb a running load
  always_ff @(posedge clk)
    if (state == IDLE && load_start)
      for (int i = 0; i < CELLS; i++) shadow[i] <= init_board[CELLS*4-1-4*i -: 4];
  // Loader FSM; strobe registers are loaded on the edge that enters BULK or SINGLE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      gap_cnt <= '0;
      bulk <= 1'b0;
      read <= 1'b0;
      block_pos <= '0;
      data <= '0;
      busy <= 1'b0;
      load_done <= 1'b0;
      err <= 1'b0;
    end else begin
      read <= 1'b0;
      load_done <= 1'b0;
      err <= 1'b0;
      if (state == IDLE) begin
        if (load_start) begin
          state <= BULK;
          bulk <= 1'b1;
          idx <= '0;
          read <= 1'b1;
          block_pos <= '0;
          data <= init_board[CELLS*4-1 -: 4];
          busy <= 1'b1;
        end else if (digit_valid) begin
          if (int'(digit_pos) < CELLS && digit_val <= 4'd9) begin
            state <= SINGLE;
            bulk <= 1'b0;
            read <= 1'b1;
            block_pos <= digit_pos;
            data <= digit_val;
            busy <= 1'b1;
          end else err <= 1'b1;
        end
      end else if (!step) begin
        state <= GAP_WAIT;
        gap_cnt <= (state == GAP_WAIT) ? gap_cnt + 4'd1 : 4'd0;
      end else begin
        gap_cnt <= '0;
        if (bulk && !last) begin
          state <= BULK;
          idx <= nxt;
          read <= 1'b1;
          block_pos <= nxt;
          data <= shadow[nxt];
        end else begin
          state <= IDLE;
          busy <= 1'b0;
          load_done <= bulk;
        end
      end
    end
endmodule

// File: tb/tb_sudoku_board_loader.sv
// tb_sudoku_board_loader: directed scenario tests for sudoku_board_loader with GAP=1
module tb_sudoku_board_loader;
  localparam int CELLS = 81;
  localparam int POS_W = 7;
  logic clk = 0, reset = 1, load_start = 0, digit_valid = 0;
  logic [CELLS*4-1:0] init_board = '0;
  logic [POS_W-1:0] digit_pos = '0;
  logic [3:0] digit_val = '0;
  logic digit_ready, read, busy, load_done, err;
  logic [POS_W-1:0] block_pos;
  logic [3:0] data;
  int checks = 0, errors = 0;

  sudoku_board_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .init_board(init_board),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .digit_pos(digit_pos),
    .digit_val(digit_val), .read(read), .block_pos(block_pos), .data(data),
    .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mod10;
    for (int i = 0; i < CELLS; i++) init_board[CELLS*4-1-4*i -: 4] = 4'(i % 10);
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({read, busy, load_done, err, block_pos, data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {read, busy, load_done, err, block_pos, data});
    end
    checks++;
    if (digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", digit_ready);
    end
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic test_bulk;
    logic [13:0] got, exp;
    int p;
    fill_mod10();
    load_start = 1;
    tick();
    load_start = 0;
    init_board = '1;
    for (int c = 0; c <= 162; c++) begin
      p = c < 162 ? c / 2 : 80;
      got = {read, busy, load_done, block_pos, data};
      exp = {c < 162 && c % 2 == 0, c < 162, c == 162, 7'(p), 4'(p % 10)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bulk c=%0d got %h exp %h", c, got, exp);
      end
      load_start = c == 50;
      if (c < 162) tick();
    end
    tick();
    checks++;
    if ({busy, load_done, read} !== 3'b000) begin
      errors++;
      $display("FAIL bulk_end got %b exp 000", {busy, load_done, read});
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    fill_mod10();
    load_start = 1;
    tick();
    load_start = 0;
    repeat (40) tick();
    checks++;
    if ({read, block_pos} !== {1'b1, 7'd20}) begin
      errors++;
      $display("FAIL mid_strobe20 got %h exp %h", {read, block_pos}, {1'b1, 7'd20});
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({read, busy, load_done, err, block_pos, data} !== '0) begin
      errors++;
      $display("FAIL mid_async_clear got %h exp 0", {read, busy, load_done, err, block_pos, data});
    end
    tick();
    reset = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (read || load_done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_abandon active_cycles %0d exp 0", bad);
    end
    load_start = 1;
    tick();
    load_start = 0;
    checks++;
    if ({read, busy, block_pos, data} !== {1'b1, 1'b1, 7'd0, 4'd0}) begin
      errors++;
      $display("FAIL mid_restart got %h exp %h", {read, busy, block_pos, data}, {1'b1, 1'b1, 7'd0, 4'd0});
    end
    repeat (170) tick();
  endtask

  task automatic test_single;
    digit_pos = 7'd40;
    digit_val = 4'd7;
    digit_valid = 1;
    #1;
    checks++;
    if (digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b exp 1", digit_ready);
    end
    tick();
    digit_valid = 0;
    checks++;
    if ({read, busy, block_pos, data} !== {1'b1, 1'b1, 7'd40, 4'd7}) begin
      errors++;
      $display("FAIL single_strobe got %h exp %h", {read, busy, block_pos, data}, {1'b1, 1'b1, 7'd40, 4'd7});
    end
    tick();
    checks++;
    if ({read, busy, block_pos, data} !== {1'b0, 1'b1, 7'd40, 4'd7}) begin
      errors++;
      $display("FAIL single_gap got %h exp %h", {read, busy, block_pos, data}, {1'b0, 1'b1, 7'd40, 4'd7});
    end
    tick();
    checks++;
    if ({read, busy, err} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle got %b exp 000", {read, busy, err});
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_ready = 5'b01001;
    logic [4:0] exp_read = 5'b10010;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin digit_valid = 1; digit_pos = 7'd3; digit_val = 4'd1; end
      if (c == 1) begin digit_pos = 7'd5; digit_val = 4'd2; end
      if (c == 4) digit_valid = 0;
      #1;
      checks++;
      if ({digit_ready, read} !== {exp_ready[c], exp_read[c]}) begin
        errors++;
        $display("FAIL b2b c=%0d ready/read got %b exp %b", c, {digit_ready, read}, {exp_ready[c], exp_read[c]});
      end
      if (c == 1 || c == 4) begin
        checks++;
        if ({block_pos, data} !== (c == 1 ? {7'd3, 4'd1} : {7'd5, 4'd2})) begin
          errors++;
          $display("FAIL b2b_data c=%0d got %h", c, {block_pos, data});
        end
      end
      if (c < 4) tick();
    end
    tick();
    tick();
  endtask

  task automatic test_bad;
    logic [POS_W-1:0] pos_t [3] = '{7'd81, 7'd10, 7'd80};
    logic [3:0] val_t [3] = '{4'd3, 4'd12, 4'd9};
    logic good;
    for (int k = 0; k < 3; k++) begin
      good = k == 2;
      digit_pos = pos_t[k];
      digit_val = val_t[k];
      digit_valid = 1;
      #1;
      checks++;
      if (digit_ready !== 1'b1) begin
        errors++;
        $display("FAIL bad%0d_ready got %b exp 1", k, digit_ready);
      end
      tick();
      digit_valid = 0;
      checks++;
      if ({read, err, busy} !== (good ? 3'b101 : 3'b010)) begin
        errors++;
        $display("FAIL bad%0d read/err/busy got %b exp %b", k, {read, err, busy}, good ? 3'b101 : 3'b010);
      end
      if (good) begin
        checks++;
        if ({block_pos, data} !== {7'd80, 4'd9}) begin
          errors++;
          $display("FAIL bad%0d_data got %h exp %h", k, {block_pos, data}, {7'd80, 4'd9});
        end
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL bad%0d_err_pulse got %b exp 0", k, err);
      end
      tick();
    end
  endtask

  task automatic test_collision;
    int n;
    fill_mod10();
    load_start = 1;
    digit_valid = 1;
    digit_pos = 7'd7;
    digit_val = 4'd4;
    #1;
    checks++;
    if (digit_ready !== 1'b0) begin
      errors++;
      $display("FAIL coll_ready got %b exp 0", digit_ready);
    end
    tick();
    load_start = 0;
    checks++;
    if ({read, block_pos, data} !== {1'b1, 7'd0, 4'd0}) begin
      errors++;
      $display("FAIL coll_bulk_first got %h exp %h", {read, block_pos, data}, {1'b1, 7'd0, 4'd0});
    end
    for (n = 0; n < 400 && !load_done; n++) tick();
    checks++;
    if (n != 162) begin
      errors++;
      $display("FAIL coll_done_time got %0d exp 162", n);
    end
    checks++;
    if (digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_ready_after got %b exp 1", digit_ready);
    end
    tick();
    digit_valid = 0;
    checks++;
    if ({read, block_pos, data, err} !== {1'b1, 7'd7, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL coll_digit got %h exp %h", {read, block_pos, data, err}, {1'b1, 7'd7, 4'd4, 1'b0});
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_bulk();
    test_reset_mid();
    test_single();
    test_back_to_back();
    test_bad();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
